pw_manager_gen: RTL

Parametrised successor to the digit-safe password manager. It holds an N-digit BCD password and an entry buffer edited with up/down/slide/place pulses, and compares on ok. It adds a failure counter, a timed error display and a timed lockout after MAX_FAIL wrong attempts. It sits between the debounced button pulses and the SSD/LED/VGA pattern logic, running on the 25.2 MHz pixel clock.

---
 rtl/pw_manager_gen_pkg.sv | 30 +++
 rtl/pw_manager_gen_if.sv | 35 +++
 rtl/pw_manager_gen_editor.sv | 71 +++++++
 rtl/pw_manager_gen.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/pw_manager_gen_pkg.sv
// Shared types and constants for the parametrised password manager.
// Holds the FSM states, pattern-select status codes and the decoded button command.
package pw_pkg;

  typedef enum logic [2:0] {ENTRY, SET, OPEN, ERR, LOCK} state_t;

  localparam logic [1:0] ST_ENTRY = 2'b00;
  localparam logic [1:0] ST_SET   = 2'b01;
  localparam logic [1:0] ST_OPEN  = 2'b10;
  localparam logic [1:0] ST_ALERT = 2'b11;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // Only the highest-priority pulse of a cycle survives decoding.
  typedef enum logic [2:0] {
    CMD_NONE, CMD_SET, CMD_ENDSET, CMD_OK, CMD_PLACE, CMD_SLIDE, CMD_UP, CMD_DOWN
  } cmd_t;

  function automatic logic [1:0] status_of(input state_t s);
    logic [1:0] code;
    case (s)
      ENTRY:   code = ST_ENTRY;
      SET:     code = ST_SET;
      OPEN:    code = ST_OPEN;
      default: code = ST_ALERT;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/pw_manager_gen_if.sv
// Button-pulse inputs and display/status outputs of the password manager.
// The slave side is the manager; the master side is whatever drives the buttons.
interface pw_manager_gen_if #(
  parameter int N_DIGITS = 4,
  parameter int MAX_FAIL = 3
);
  localparam int POS_W  = $clog2(N_DIGITS);
  localparam int FAIL_W = $clog2(MAX_FAIL + 1);

  logic                  pw_set;
  logic                  pw_endset;
  logic                  up;
  logic                  down;
  logic                  slide;
  logic                  place;
  logic                  ok;
  logic [3:0]            cur_digit;
  logic [POS_W-1:0]      cur_pos;
  logic [4*N_DIGITS-1:0] entry_flat;
  logic [1:0]            status;
  logic                  led_r;
  logic                  led_g;
  logic [FAIL_W-1:0]     fail_cnt;
  logic                  lock_active;

  modport master (
    output pw_set, pw_endset, up, down, slide, place, ok,
    input  cur_digit, cur_pos, entry_flat, status, led_r, led_g, fail_cnt, lock_active
  );

  modport slave (
    input  pw_set, pw_endset, up, down, slide, place, ok,
    output cur_digit, cur_pos, entry_flat, status, led_r, led_g, fail_cnt, lock_active
  );
endinterface

// File: rtl/pw_manager_gen_editor.sv
// Cursor, working BCD digit and entry buffer. Edit pulses arrive already
// priority-resolved; clear wins over everything and resets all three.
module pw_digit_editor
  import pw_pkg::*;
#(
  parameter int N_DIGITS = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         clear_i,
  input  logic                         en_i,
  input  logic                         up_i,
  input  logic                         down_i,
  input  logic                         slide_i,
  input  logic                         place_i,
  output logic [3:0]                   cur_digit_o,
  output logic [$clog2(N_DIGITS)-1:0]  cur_pos_o,
  output logic [4*N_DIGITS-1:0]        entry_flat_o
);
  localparam int POS_W = $clog2(N_DIGITS);

  logic [3:0]       digit_q, digit_d;
  logic [POS_W-1:0] pos_q, pos_d, pos_next;

  assign pos_next = (pos_q == POS_W'(N_DIGITS - 1)) ? '0 : pos_q + POS_W'(1);

  always_comb begin
    digit_d = digit_q;
    pos_d   = pos_q;
    if (clear_i) begin
      digit_d = '0;
      pos_d   = '0;
    end else if (en_i) begin
      if (place_i || slide_i) begin
        pos_d = pos_next;
      end else if (up_i) begin
        digit_d = (digit_q == BCD_MAX) ? 4'd0 : digit_q + 4'd1;
      end else if (down_i) begin
        digit_d = (digit_q == 4'd0) ? BCD_MAX : digit_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      digit_q <= '0;
      pos_q   <= '0;
    end else begin
      digit_q <= digit_d;
      pos_q   <= pos_d;
    end
  end

  for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
    logic [3:0] val_q;

    always_ff @(posedge clk) begin
      if (!reset_n || clear_i) begin
        val_q <= '0;
      end else if (en_i && place_i && (pos_q == POS_W'(gi))) begin
        val_q <= digit_q;
      end
    end

    assign entry_flat_o[4*gi +: 4] = val_q;
  end

  assign cur_digit_o = digit_q;
  assign cur_pos_o   = pos_q;

endmodule

// File: rtl/pw_manager_gen.sv
// Password manager top: mode FSM, password register, comparator, failure
// counter and the shared ERR/LOCK countdown. Digit editing lives in pw_digit_editor.
module pw_manager_gen
  import pw_pkg::*;
#(
  parameter int N_DIGITS    = 4,
  parameter int MAX_FAIL    = 3,
  parameter int ERR_CYCLES  = 25_200_000,
  parameter int LOCK_CYCLES = 252_000_000
) (
  input  logic             clk,
  input  logic             reset_n,
  pw_manager_gen_if.slave  bus
);
  localparam int FAIL_W  = $clog2(MAX_FAIL + 1);
  localparam int CYC_MAX = (ERR_CYCLES > LOCK_CYCLES) ? ERR_CYCLES : LOCK_CYCLES;
  localparam int TMR_W   = $clog2(CYC_MAX + 1);
  localparam logic [TMR_W-1:0]  ERR_LOAD  = TMR_W'(ERR_CYCLES - 1);
  localparam logic [TMR_W-1:0]  LOCK_LOAD = TMR_W'(LOCK_CYCLES - 1);
  localparam logic [FAIL_W-1:0] FAIL_LIM  = FAIL_W'(MAX_FAIL);

  state_t                state_q, state_d;
  logic [TMR_W-1:0]      timer_q, timer_d;
  logic [FAIL_W-1:0]     fail_q, fail_d, fail_inc;
  logic [4*N_DIGITS-1:0] pw_q, pw_d;
  logic [1:0]            status_q;
  logic                  led_r_q, led_g_q, lock_q;
  logic                  clear, edit_en;
  cmd_t                  cmd;
  logic [4*N_DIGITS-1:0] entry_flat;

  always_comb begin
    cmd = CMD_NONE;
    if      (bus.pw_set)    cmd = CMD_SET;
    else if (bus.pw_endset) cmd = CMD_ENDSET;
    else if (bus.ok)        cmd = CMD_OK;
    else if (bus.place)     cmd = CMD_PLACE;
    else if (bus.slide)     cmd = CMD_SLIDE;
    else if (bus.up)        cmd = CMD_UP;
    else if (bus.down)      cmd = CMD_DOWN;
  end

  assign fail_inc = (fail_q == FAIL_LIM) ? fail_q : fail_q + FAIL_W'(1);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    fail_d  = fail_q;
    pw_d    = pw_q;
    clear   = 1'b0;
    edit_en = 1'b0;
    case (state_q)
      ENTRY: begin
        edit_en = 1'b1;
        if (cmd == CMD_OK) begin
          if (entry_flat == pw_q) begin
            state_d = OPEN;
            fail_d  = '0;
          end else begin
            fail_d = fail_inc;
            if (fail_inc == FAIL_LIM) begin
              state_d = LOCK;
              timer_d = LOCK_LOAD;
            end else begin
              state_d = ERR;
              timer_d = ERR_LOAD;
            end
          end
        end
      end
      SET: begin
        edit_en = 1'b1;
        if (cmd == CMD_ENDSET) begin
          pw_d    = entry_flat;
          state_d = ENTRY;
          clear   = 1'b1;
        end
      end
      OPEN: begin
        if (cmd == CMD_SET) begin
          state_d = SET;
          clear   = 1'b1;
        end else if (cmd == CMD_OK) begin
          state_d = ENTRY;
          clear   = 1'b1;
        end
      end
      ERR, LOCK: begin
        if (timer_q == '0) begin
          state_d = ENTRY;
          clear   = 1'b1;
          if (state_q == LOCK) fail_d = '0;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      default: begin
        state_d = ENTRY;
        clear   = 1'b1;
      end
    endcase
  end

  // Status outputs are registered from the next state so they share the editor's latency.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= ENTRY;
      timer_q  <= '0;
      fail_q   <= '0;
      pw_q     <= '0;
      status_q <= ST_ENTRY;
      led_r_q  <= 1'b1;
      led_g_q  <= 1'b0;
      lock_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      fail_q   <= fail_d;
      pw_q     <= pw_d;
      status_q <= status_of(state_d);
      led_r_q  <= (state_d inside {ENTRY, ERR, LOCK});
      led_g_q  <= (state_d inside {OPEN, SET});
      lock_q   <= (state_d == LOCK);
    end
  end

  pw_digit_editor #(.N_DIGITS(N_DIGITS)) u_editor (
    .clk          (clk),
    .reset_n      (reset_n),
    .clear_i      (clear),
    .en_i         (edit_en),
    .up_i         (cmd == CMD_UP),
    .down_i       (cmd == CMD_DOWN),
    .slide_i      (cmd == CMD_SLIDE),
    .place_i      (cmd == CMD_PLACE),
    .cur_digit_o  (bus.cur_digit),
    .cur_pos_o    (bus.cur_pos),
    .entry_flat_o (entry_flat)
  );

  assign bus.entry_flat  = entry_flat;
  assign bus.status      = status_q;
  assign bus.led_r       = led_r_q;
  assign bus.led_g       = led_g_q;
  assign bus.fail_cnt    = fail_q;
  assign bus.lock_active = lock_q;

endmodule
